// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC vector engine.
package mac_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } mac_state_e;

    // Widest accumulator the bound helpers can describe.
    localparam int unsigned MaxAccW = 64;

    // Largest representable accumulator value for the given width and signedness.
    function automatic logic [MaxAccW-1:0] sat_max(input int unsigned acc_w,
                                                   input logic        is_signed);
        if (is_signed) begin
            return (MaxAccW'(1) << (acc_w - 1)) - MaxAccW'(1);
        end else if (acc_w >= MaxAccW) begin
            return '1;
        end else begin
            return (MaxAccW'(1) << acc_w) - MaxAccW'(1);
        end
    endfunction

    // Smallest representable accumulator value (bit pattern in acc_w bits).
    function automatic logic [MaxAccW-1:0] sat_min(input int unsigned acc_w,
                                                   input logic        is_signed);
        if (is_signed) begin
            return MaxAccW'(1) << (acc_w - 1);
        end else begin
            return '0;
        end
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Stage 1: registered signed/unsigned multiplier with a valid flag.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  in_fire,
    input  logic                  is_signed,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   prod,
    output logic                  prod_valid
);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod_d;

    // Extend operands to full product width; the truncated product is then exact
    // for both signed and unsigned interpretations.
    always_comb begin
        a_ext  = {{DATA_W{is_signed & a[DATA_W-1]}}, a};
        b_ext  = {{DATA_W{is_signed & b[DATA_W-1]}}, b};
        prod_d = a_ext * b_ext;
    end

    // Capture a product per accepted beat; a bubble clears the valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod       <= '0;
            prod_valid <= 1'b0;
        end else if (ena) begin
            prod_valid <= in_fire;
            if (in_fire) begin
                prod <= prod_d;
            end
        end
    end

endmodule

// File: rtl/mac_vector_engine.sv
// Dot-product engine: accepts a job config, accumulates len operand products,
// then presents the result until it is taken.
module mac_vector_engine
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_signed,
    input  logic              cfg_sat,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              busy
);

    localparam int unsigned ProdW = 2 * DATA_W;

    mac_state_e         state_q, state_d;
    logic [LEN_W-1:0]   len_cnt_q;
    logic               mode_signed_q;
    logic               mode_sat_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;

    logic               cfg_fire, in_fire, out_fire;
    logic [ProdW-1:0]   prod;
    logic               prod_valid;

    logic [ACC_W:0]     acc_ext, prod_ext, sum;
    logic               add_ovf;
    logic [ACC_W-1:0]   acc_max, acc_min, acc_nxt;

    assign cfg_fire = cfg_valid & cfg_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready & ena;

    mac_mult_stage #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_fire    (in_fire),
        .is_signed  (mode_signed_q),
        .a          (in_a),
        .b          (in_b),
        .prod       (prod),
        .prod_valid (prod_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DRAIN ends on the edge that accumulates the last product.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_fire) begin
                    state_d = (cfg_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (in_fire && len_cnt_q == LEN_W'(1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (prod_valid) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs; readies are gated by ena and held low during reset.
    always_comb begin
        cfg_ready = rst_n & ena & (state_q == StIdle);
        in_ready  = rst_n & ena & (state_q == StRun);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
    end

    // Stage 2 adder: exact sum in ACC_W+1 bits, overflow detect and clamp.
    always_comb begin
        acc_ext  = {mode_signed_q & acc_q[ACC_W-1], acc_q};
        prod_ext = {{(ACC_W + 1 - ProdW){mode_signed_q & prod[ProdW-1]}}, prod};
        sum      = acc_ext + prod_ext;
        add_ovf  = mode_signed_q ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
        acc_max  = ACC_W'(sat_max(ACC_W, mode_signed_q));
        acc_min  = ACC_W'(sat_min(ACC_W, mode_signed_q));
        acc_nxt  = sum[ACC_W-1:0];
        // Unsigned adds are non-negative, so unsigned overflow always clamps high.
        if (add_ovf && mode_sat_q) begin
            acc_nxt = (mode_signed_q && sum[ACC_W]) ? acc_min : acc_max;
        end
    end

    // Job config latch, beat counter, accumulator and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt_q     <= '0;
            mode_signed_q <= 1'b0;
            mode_sat_q    <= 1'b0;
            acc_q         <= '0;
            ovf_q         <= 1'b0;
        end else if (ena) begin
            if (cfg_fire) begin
                len_cnt_q     <= cfg_len;
                mode_signed_q <= cfg_signed;
                mode_sat_q    <= cfg_sat;
                acc_q         <= '0;
                ovf_q         <= 1'b0;
            end else begin
                if (prod_valid) begin
                    acc_q <= acc_nxt;
                    ovf_q <= ovf_q | add_ovf;
                end
                if (in_fire) begin
                    len_cnt_q <= len_cnt_q - LEN_W'(1);
                end
            end
        end
    end

    assign out_acc = acc_q;
    assign out_ovf = ovf_q;

endmodule

// File: tb/tb_mac_vector_engine.sv
// Self-checking bench for mac_vector_engine: table of jobs plus corner sequences,
// results checked through a scoreboard queue.
module tb_mac_vector_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        cfg_valid;
    logic [7:0]  cfg_len;
    logic        cfg_signed;
    logic        cfg_sat;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_ready;

    logic        cfg_ready, in_ready, out_valid, out_ovf, busy;
    logic [23:0] out_acc;
    logic        cfg_ready16, in_ready16, out_valid16, out_ovf16, busy16;
    logic [15:0] out_acc16;

    always #5 clk = ~clk;

    mac_vector_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_len    (cfg_len),
        .cfg_signed (cfg_signed),
        .cfg_sat    (cfg_sat),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_ovf    (out_ovf),
        .busy       (busy)
    );

    mac_vector_engine #(
        .ACC_W (16)
    ) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready16),
        .cfg_len    (cfg_len),
        .cfg_signed (cfg_signed),
        .cfg_sat    (cfg_sat),
        .in_valid   (in_valid),
        .in_ready   (in_ready16),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid16),
        .out_ready  (out_ready),
        .out_acc    (out_acc16),
        .out_ovf    (out_ovf16),
        .busy       (busy16)
    );

    typedef struct packed {
        logic            sgn;
        logic            sat;
        logic            use16;
        logic [7:0]      len;
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic [23:0]     exp_acc;
        logic            exp_ovf;
    } vec_t;

    typedef struct {
        logic        use16;
        logic [23:0] acc;
        logic        ovf;
        int          id;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && ena && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.use16) begin
                    check($sformatf("job%0d_acc16", e.id), 32'(out_acc16), 32'(e.acc));
                    check($sformatf("job%0d_ovf16", e.id), 32'(out_ovf16), 32'(e.ovf));
                end else begin
                    check($sformatf("job%0d_acc", e.id), 32'(out_acc), 32'(e.acc));
                    check($sformatf("job%0d_ovf", e.id), 32'(out_ovf), 32'(e.ovf));
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_cfg(input logic [7:0] len, input logic sgn, input logic sat);
        int   n = 0;
        logic rdy;
        cfg_len = len; cfg_signed = sgn; cfg_sat = sat; cfg_valid = 1'b1;
        do begin
            @(negedge clk); rdy = cfg_ready && ena;
            @(posedge clk); #1; n++;
        end while (!rdy && n < 50);
        if (!rdy) check("cfg_handshake_timeout", 32'd0, 32'd1);
        cfg_valid = 1'b0;
    endtask

    task automatic do_beat(input logic [7:0] a, input logic [7:0] b);
        int   n = 0;
        logic rdy;
        in_a = a; in_b = b; in_valid = 1'b1;
        do begin
            @(negedge clk); rdy = in_ready && ena;
            @(posedge clk); #1; n++;
        end while (!rdy && n < 50);
        if (!rdy) check("in_handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_sb_empty(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (sb.size() != 0) begin
            check({name, "_result_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_job(input vec_t v, input bit gaps, input int id);
        sb.push_back('{use16: v.use16, acc: v.exp_acc, ovf: v.exp_ovf, id: id});
        do_cfg(v.len, v.sgn, v.sat);
        for (int i = 0; i < int'(v.len); i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                if (i == 2) begin
                    // Beat presented while frozen must not be taken.
                    in_a = v.a[i]; in_b = v.b[i]; in_valid = 1'b1; ena = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        check("in_ready_low_when_frozen", 32'(in_ready), 32'd0);
                        @(posedge clk); #1;
                    end
                    ena = 1'b1;
                end
            end
            do_beat(v.a[i], v.b[i]);
        end
        in_valid = 1'b0;
        if (!gaps) begin
            check($sformatf("job%0d_drain_busy", id), 32'(busy), 32'd1);
            check($sformatf("job%0d_drain_no_valid", id), 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            check($sformatf("job%0d_valid_2cyc", id), 32'(out_valid), 32'd1);
        end
        wait_sb_empty($sformatf("job%0d", id));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{sgn: 1'b0, sat: 1'b0, use16: 1'b0, len: 8'd4,
                    a: {8'd7, 8'd5, 8'd3, 8'd1}, b: {8'd8, 8'd6, 8'd4, 8'd2},
                    exp_acc: 24'd100, exp_ovf: 1'b0};
        vecs[1] = '{sgn: 1'b1, sat: 1'b0, use16: 1'b0, len: 8'd3,
                    a: {8'd0, 8'd5, 8'hFF, 8'h80}, b: {8'd0, 8'hFD, 8'hFF, 8'h7F},
                    exp_acc: 24'hFFC072, exp_ovf: 1'b0};
        vecs[2] = '{sgn: 1'b0, sat: 1'b1, use16: 1'b1, len: 8'd2,
                    a: {8'd0, 8'd0, 8'hFF, 8'hFF}, b: {8'd0, 8'd0, 8'hFF, 8'hFF},
                    exp_acc: 24'h00FFFF, exp_ovf: 1'b1};
        vecs[3] = '{sgn: 1'b0, sat: 1'b0, use16: 1'b1, len: 8'd2,
                    a: {8'd0, 8'd0, 8'hFF, 8'hFF}, b: {8'd0, 8'd0, 8'hFF, 8'hFF},
                    exp_acc: 24'h00FC02, exp_ovf: 1'b1};
        // -16256 x3 clamps at -32768, then +16129 continues from the clamp.
        vecs[4] = '{sgn: 1'b1, sat: 1'b1, use16: 1'b1, len: 8'd4,
                    a: {8'h7F, 8'h80, 8'h80, 8'h80}, b: {8'h7F, 8'h7F, 8'h7F, 8'h7F},
                    exp_acc: 24'h00BF01, exp_ovf: 1'b1};
        // Same job wrapping: -48768 -> 0x4180, +16129 -> 0x8081.
        vecs[5] = '{sgn: 1'b1, sat: 1'b0, use16: 1'b1, len: 8'd4,
                    a: {8'h7F, 8'h80, 8'h80, 8'h80}, b: {8'h7F, 8'h7F, 8'h7F, 8'h7F},
                    exp_acc: 24'h008081, exp_ovf: 1'b1};
        vecs[6] = '{sgn: 1'b0, sat: 1'b0, use16: 1'b0, len: 8'd1,
                    a: {8'd0, 8'd0, 8'd0, 8'd3}, b: {8'd0, 8'd0, 8'd0, 8'd3},
                    exp_acc: 24'd9, exp_ovf: 1'b0};

        rst_n = 1'b0; ena = 1'b1; cfg_valid = 1'b0; cfg_len = '0; cfg_signed = 1'b0;
        cfg_sat = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_acc", 32'(out_acc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i], 1'b0, i);
        end

        // Zero-length job with a stalled consumer.
        out_ready = 1'b0;
        sb.push_back('{use16: 1'b0, acc: 24'd0, ovf: 1'b0, id: 10});
        do_cfg(8'd0, 1'b0, 1'b0);
        check("len0_valid_next", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("len0_acc_stable", 32'(out_acc), 32'd0);
            check("len0_cfg_ready_low", 32'(cfg_ready), 32'd0);
            check("len0_valid_held", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_sb_empty("len0");
        check("len0_valid_drop", 32'(out_valid), 32'd0);
        check("len0_back_idle", 32'(cfg_ready), 32'd1);

        // Random in_valid gaps and a 3-cycle enable drop.
        run_job(vecs[0], 1'b1, 20);

        // Reset in the middle of a job.
        do_cfg(8'd4, 1'b0, 1'b0);
        do_beat(8'd9, 8'd9);
        do_beat(8'd9, 8'd9);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_acc", 32'(out_acc), 32'd0);
        check("midrst_out_ovf", 32'(out_ovf), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_release_cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk); #1;
        run_job(vecs[6], 1'b0, 30);

        repeat (3) @(posedge clk);
        #1;
        check("no_leftover_results", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_vector_engine.md
MAC_VECTOR_ENGINE -- requirements
Module: mac_vector_engine

Interface
REQ-001 Parameter DATA_W, default 8, operand width in bits.
REQ-002 Parameter ACC_W, default 24, accumulator/result width in bits; SHALL be >= 2*DATA_W.
REQ-003 Parameter LEN_W, default 8, vector-length field width in bits.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ena  input  1  global enable; low freezes all state and forces every ready output low.
REQ-007 cfg_valid / cfg_ready  input / output  1 / 1  job-start handshake.
REQ-008 cfg_len  input  LEN_W  number of operand pairs in the job.
REQ-009 cfg_signed  input  1  1 = two's-complement operands and accumulator, 0 = unsigned.
REQ-010 cfg_sat  input  1  1 = saturating accumulate, 0 = modular wrap.
REQ-011 in_valid / in_ready  input / output  1 / 1  operand-pair handshake.
REQ-012 in_a, in_b  input  DATA_W each  operand pair.
REQ-013 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-014 out_acc  output  ACC_W  final dot-product result.
REQ-015 out_ovf  output  1  sticky: an overflow occurred during the job (both modes).
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 A transfer occurs on a channel only on a rising edge where valid, ready and ena are all high.
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; cfg_ready is high only in IDLE; in_ready is high only in RUN.
REQ-019 IDLE -> RUN on a cfg transfer with cfg_len > 0; mode bits and length are latched, accumulator and out_ovf cleared.
REQ-020 IDLE -> DONE on a cfg transfer with cfg_len == 0; out_acc = 0, out_ovf = 0, out_valid high on the next cycle.
REQ-021 Each in transfer registers the product in_a*in_b (2*DATA_W, signedness per latched mode) in stage 1; stage 2 adds it, sign- or zero-extended, into the accumulator on the following enabled cycle.
REQ-022 The beat counter decrements per in transfer; the transfer that brings it to 0 moves RUN -> DRAIN, and in_ready drops on the next cycle.
REQ-023 DRAIN lasts until the last product is accumulated; out_valid rises exactly 2 enabled cycles after the last in transfer.
REQ-024 In DONE, out_valid stays high and out_acc/out_ovf stay stable until an out transfer; then -> IDLE, out_valid low next cycle.
REQ-025 Overflow: an accumulate whose exact result falls outside the ACC_W range of the latched mode sets out_ovf.
REQ-026 On overflow with cfg_sat=1, the accumulator clamps to max (signed 2^(ACC_W-1)-1, unsigned 2^ACC_W-1) or min (signed -2^(ACC_W-1), unsigned 0) and further adds continue from the clamped value.
REQ-027 On overflow with cfg_sat=0, the accumulator keeps the low ACC_W bits of the exact sum.
REQ-028 in_valid gaps stall RUN without loss; pipeline bubbles never modify the accumulator.
REQ-029 ena low for any number of cycles resumes with identical results; no handshake completes while ena is low.
REQ-030 cfg_valid outside IDLE and in_valid outside RUN are ignored.

Reset
REQ-031 While rst_n is low: state IDLE, cfg_ready 0, in_ready 0, out_valid 0, out_acc 0, out_ovf 0, busy 0, pipeline and counter cleared.
REQ-032 Reset asserted mid-job discards the job; after release the first enabled cycle shows cfg_ready high.

Structure
REQ-033 Shared package mac_pkg holds the FSM state enum and the saturation-bound helper functions.
REQ-034 Sub-module mac_mult_stage implements the registered signed/unsigned multiplier of stage 1; accumulator, counter and FSM stay in mac_vector_engine.

Verification
REQ-035 Defaults, unsigned, wrap, len=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back -> out_acc=100, out_ovf=0, out_valid 2 cycles after the 4th beat.
REQ-036 Signed, len=3, pairs (-128,127),(-1,-1),(5,-3) -> out_acc=-16270 (0xFFC072), out_ovf=0.
REQ-037 Unsigned, sat, ACC_W=16, len=2, pairs (255,255),(255,255) -> out_acc=0xFFFF, out_ovf=1; same job with wrap -> out_acc=0xFC02, out_ovf=1.
REQ-038 len=0 -> out_valid next cycle, out_acc=0; out_ready held low 5 cycles -> result stable, cfg_ready low throughout.
REQ-039 len=4 with random in_valid gaps and ena dropped 3 cycles mid-job -> result identical to REQ-035.
REQ-040 rst_n pulsed low after 2 beats of a len=4 job -> all outputs 0 during reset; following len=1 job (3,3) -> out_acc=9.
